// File: rtl/pio_host_if_pkg.sv
// Shared definitions for the PIO host action bus: action codes, register
// reset values, register field positions and the action-to-field decode.
package pio_defs;

  typedef enum logic [3:0] {
    ACT_NONE   = 4'd0,
    ACT_INSTR  = 4'd1,
    ACT_PEND   = 4'd2,
    ACT_PULL   = 4'd3,
    ACT_PUSH   = 4'd4,
    ACT_GRPS   = 4'd5,
    ACT_EN     = 4'd6,
    ACT_DIV    = 4'd7,
    ACT_SIDES  = 4'd8,
    ACT_IMM    = 4'd9,
    ACT_SHIFT  = 4'd10,
    ACT_ERRCLR = 4'd11
  } action_e;

  // Which per-machine register an action targets.
  typedef enum logic [2:0] {
    FLD_NONE  = 3'd0,
    FLD_EXEC  = 3'd1,
    FLD_DIV   = 3'd2,
    FLD_GRPS  = 3'd3,
    FLD_SIDES = 3'd4,
    FLD_SHIFT = 3'd5
  } field_e;

  localparam int          DIV_W           = 24;
  localparam logic [31:0] EXEC_RESET_DEF  = 32'h0001_F000;
  localparam logic [23:0] DIV_RESET_DEF   = 24'h00_0100;

  // exec_ctrl field positions
  localparam int WRAP_TOP_MSB    = 16;
  localparam int WRAP_TOP_LSB    = 12;
  localparam int WRAP_BOT_MSB    = 11;
  localparam int WRAP_BOT_LSB    = 7;
  localparam int SET_COUNT_MSB   = 28;
  localparam int SET_COUNT_LSB   = 26;

  // clk_div 16.8 fixed-point field positions
  localparam int DIV_INT_MSB     = 23;
  localparam int DIV_INT_LSB     = 8;
  localparam int DIV_FRAC_MSB    = 7;
  localparam int DIV_FRAC_LSB    = 0;

  // Map an action code onto the per-machine register it writes.
  function automatic field_e field_of(input logic [3:0] act);
    case (act)
      ACT_PEND:  return FLD_EXEC;
      ACT_DIV:   return FLD_DIV;
      ACT_GRPS:  return FLD_GRPS;
      ACT_SIDES: return FLD_SIDES;
      ACT_SHIFT: return FLD_SHIFT;
      default:   return FLD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/pio_host_if_sm_regs.sv
// Configuration register slice for one state machine. A single write enable
// plus a field select picks which of the five registers takes din.
module pio_host_sm_regs
  import pio_defs::*;
#(
  parameter logic [31:0] EXEC_RESET = EXEC_RESET_DEF,
  parameter logic [23:0] DIV_RESET  = DIV_RESET_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  field_e           fsel,
  input  logic [31:0]      din,
  output logic [31:0]      exec_ctrl,
  output logic [DIV_W-1:0] clk_div,
  output logic [31:0]      pin_grps,
  output logic [31:0]      sides,
  output logic [31:0]      shift_ctrl
);

  // Write the selected register; a divider of zero is stored untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      exec_ctrl  <= EXEC_RESET;
      clk_div    <= DIV_RESET;
      pin_grps   <= '0;
      sides      <= '0;
      shift_ctrl <= '0;
    end else if (we) begin
      case (fsel)
        FLD_EXEC:  exec_ctrl  <= din;
        FLD_DIV:   clk_div    <= din[DIV_W-1:0];
        FLD_GRPS:  pin_grps   <= din;
        FLD_SIDES: sides      <= din;
        FLD_SHIFT: shift_ctrl <= din;
        default:   ;
      endcase
    end
  end

endmodule

// File: rtl/pio_host_if.sv
// Responder for the PIO host action bus: decodes one action per clock into
// instruction writes, config register writes, enable/restart, immediate
// instructions and TX/RX FIFO handshakes.
module pio_host_if
  import pio_defs::*;
#(
  parameter int          NUM_SM     = 4,
  parameter int          IMEM_DEPTH = 32,
  parameter logic [23:0] DIV_RESET  = DIV_RESET_DEF,
  parameter logic [31:0] EXEC_RESET = EXEC_RESET_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    action,
  input  logic [$clog2(IMEM_DEPTH)-1:0] index,
  input  logic [$clog2(NUM_SM)-1:0]     mindex,
  input  logic [31:0]                   din,
  output logic [31:0]                   dout,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  output logic [15:0]                   imem_wdata,
  output logic [NUM_SM*32-1:0]          exec_ctrl,
  output logic [NUM_SM*24-1:0]          clk_div,
  output logic [NUM_SM*32-1:0]          pin_grps,
  output logic [NUM_SM*32-1:0]          sides,
  output logic [NUM_SM*32-1:0]          shift_ctrl,
  output logic [NUM_SM-1:0]             en,
  output logic [NUM_SM-1:0]             restart,
  output logic [NUM_SM-1:0]             imm_valid,
  output logic [15:0]                   imm_instr,
  output logic [NUM_SM-1:0]             tx_push,
  output logic [31:0]                   tx_data,
  input  logic [NUM_SM-1:0]             tx_full,
  output logic [NUM_SM-1:0]             rx_pop,
  input  logic [NUM_SM*32-1:0]          rx_data,
  input  logic [NUM_SM-1:0]             rx_empty,
  output logic                          err_ovf,
  output logic                          err_unf
);

  localparam int MW = $clog2(NUM_SM);

  field_e fsel;
  assign fsel    = field_of(action);
  assign tx_data = din;

  // FIFO strobes are combinational so the FIFO acts within the same cycle.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    tx_push = '0;
    rx_pop  = '0;
    if (!reset) begin
      if (action == ACT_PUSH && !tx_full[mindex])  tx_push[mindex] = 1'b1;
      if (action == ACT_PULL && !rx_empty[mindex]) rx_pop[mindex]  = 1'b1;
    end
  end

  // One-cycle instruction memory write following an INSTR action.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= (action == ACT_INSTR);
      if (action == ACT_INSTR) begin
        imem_waddr <= index;
        imem_wdata <= din[15:0];
      end
    end
  end

  // Enable mask with a restart pulse for each machine going 0->1.
  always_ff @(posedge clk) begin
    if (reset) begin
      en      <= '0;
      restart <= '0;
    end else begin
      restart <= '0;
      if (action == ACT_EN) begin
        en      <= din[NUM_SM-1:0];
        restart <= din[NUM_SM-1:0] & ~en;
      end
    end
  end

  // Immediate instruction strobe; the instruction word holds afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      imm_valid <= '0;
      imm_instr <= '0;
    end else begin
      imm_valid <= '0;
      if (action == ACT_IMM) begin
        imm_valid[mindex] <= 1'b1;
        imm_instr         <= din[15:0];
      end
    end
  end

  // RX capture and sticky overflow/underflow flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout    <= '0;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      case (action)
        ACT_PUSH: if (tx_full[mindex]) err_ovf <= 1'b1;
        ACT_PULL: begin
          if (rx_empty[mindex]) err_unf <= 1'b1;
          else                  dout    <= rx_data[mindex*32 +: 32];
        end
        ACT_ERRCLR: begin
          err_ovf <= 1'b0;
          err_unf <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_SM; i++) begin : g_sm
    pio_host_sm_regs #(
      .EXEC_RESET (EXEC_RESET),
      .DIV_RESET  (DIV_RESET)
    ) u_regs (
      .clk        (clk),
      .reset      (reset),
      .we         ((fsel != FLD_NONE) && (mindex == MW'(i))),
      .fsel       (fsel),
      .din        (din),
      .exec_ctrl  (exec_ctrl[i*32 +: 32]),
      .clk_div    (clk_div[i*24 +: 24]),
      .pin_grps   (pin_grps[i*32 +: 32]),
      .sides      (sides[i*32 +: 32]),
      .shift_ctrl (shift_ctrl[i*32 +: 32])
    );
  end

endmodule
